// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit: tracks in-flight register writes, drives the ID stall,
// per-source forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int AW         = 4,
    parameter int NSRC       = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int CW         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              forward_enable,
    input  logic              id_valid,
    input  logic [NSRC*AW-1:0] id_src,
    input  logic [NSRC-1:0]   id_src_used,
    input  logic [AW-1:0]     id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              flush,
    output logic              hazard_detected,
    output logic [2*NSRC-1:0] fwd_sel,
    output logic [CW-1:0]     stall_count
);

    localparam int NREG = 1 << AW;
    localparam int CNTW = $clog2(PIPE_DEPTH + 1);

    // cnt values naming where the youngest producer of a register currently sits
    localparam logic [CNTW-1:0] CNT_EXE     = CNTW'(PIPE_DEPTH);
    localparam logic [CNTW-1:0] CNT_MEM     = CNTW'(PIPE_DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_BUB_LO  = CNTW'(2);
    localparam logic [CNTW-1:0] CNT_BUB_HI  = CNTW'(PIPE_DEPTH - 2);
    localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] ld;

    logic [CNTW-1:0] src_cnt [NSRC];
    logic [NSRC-1:0] src_ld;
    logic [NSRC-1:0] conflict;
    logic            issue;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_cnt[i] = cnt[id_src[i*AW +: AW]];
            src_ld[i]  = ld[id_src[i*AW +: AW]];
        end
    end

    // Forwarding covers EXE (except loads) and MEM; anything older than MEM but not yet
    // in WB is unreachable by the bypass network and must stall.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i]) begin
                if (forward_enable) begin
                    conflict[i] = ((src_cnt[i] == CNT_EXE) && src_ld[i]) ||
                                  ((src_cnt[i] >= CNT_BUB_LO) && (src_cnt[i] <= CNT_BUB_HI));
                end else begin
                    conflict[i] = (src_cnt[i] > CNT_ONE);
                end
            end
        end
    end

    assign hazard_detected = id_valid & ~flush & (|conflict);
    assign issue           = id_valid & ~flush & ~hazard_detected;

    always_comb begin
        fwd_sel = '0;
        if (forward_enable && !hazard_detected) begin
            for (int i = 0; i < NSRC; i++) begin
                if (id_src_used[i]) begin
                    if (src_cnt[i] == CNT_EXE) begin
                        fwd_sel[2*i +: 2] = 2'd1;
                    end else if (src_cnt[i] == CNT_MEM) begin
                        fwd_sel[2*i +: 2] = 2'd2;
                    end
                end
            end
        end
    end

    // A new writer overrides the decrement so the newest producer always wins on WAW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            ld <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && id_wb_en && (id_dest == AW'(r))) begin
                    cnt[r] <= CNT_EXE;
                    ld[r]  <= id_mem_r_en;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                    if (cnt[r] == CNT_ONE) begin
                        ld[r] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hazard_detected && (stall_count != {CW{1'b1}})) begin
            stall_count <= stall_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (default, CW=2, PIPE_DEPTH=5/NSRC=3) checked
// every cycle against an issue-history model, plus directed literal expectations.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus for the default instance and its CW=2 twin
    logic       fe, valid, flush, wb, mr;
    logic [7:0] src;
    logic [1:0] used;
    logic [3:0] dest;
    logic       haz_a, haz_c;
    logic [3:0] fwd_a, fwd_c;
    logic [15:0] stall_a;
    logic [1:0]  stall_c;

    logic        fe_b, valid_b, flush_b, wb_b, mr_b;
    logic [11:0] src_b;
    logic [2:0]  used_b;
    logic [3:0]  dest_b;
    logic        haz_b;
    logic [5:0]  fwd_b;
    logic [15:0] stall_b;

    hazard_scoreboard u_a (
        .clk(clk), .rst_n(rst_n), .forward_enable(fe), .id_valid(valid), .id_src(src),
        .id_src_used(used), .id_dest(dest), .id_wb_en(wb), .id_mem_r_en(mr), .flush(flush),
        .hazard_detected(haz_a), .fwd_sel(fwd_a), .stall_count(stall_a)
    );

    hazard_scoreboard #(.CW(2)) u_c (
        .clk(clk), .rst_n(rst_n), .forward_enable(fe), .id_valid(valid), .id_src(src),
        .id_src_used(used), .id_dest(dest), .id_wb_en(wb), .id_mem_r_en(mr), .flush(flush),
        .hazard_detected(haz_c), .fwd_sel(fwd_c), .stall_count(stall_c)
    );

    hazard_scoreboard #(.NSRC(3), .PIPE_DEPTH(5)) u_b (
        .clk(clk), .rst_n(rst_n), .forward_enable(fe_b), .id_valid(valid_b), .id_src(src_b),
        .id_src_used(used_b), .id_dest(dest_b), .id_wb_en(wb_b), .id_mem_r_en(mr_b),
        .flush(flush_b), .hazard_detected(haz_b), .fwd_sel(fwd_b), .stall_count(stall_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: per register, the cycle its youngest writer issued and whether it was a load.
    int last_a [16];
    int last_b [16];
    bit ld_a [16];
    bit ld_b [16];
    int stalls_a, stalls_b;

    function automatic int cnt_of(input int last, input int pd, input int now);
        if (last < 0) return 0;
        if (now - last > pd) return 0;
        return pd - (now - last) + 1;
    endfunction

    function automatic bit conflict_of(input bit f, input int c, input bit l, input int pd);
        if (f) return (c == pd && l) || (c >= 2 && c <= pd - 2);
        return c > 1;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int c, s, ef;
        bit any, eh;
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) begin
                last_a[r] = -1; ld_a[r] = 1'b0;
                last_b[r] = -1; ld_b[r] = 1'b0;
            end
            stalls_a = 0;
            stalls_b = 0;
            chk("rst_haz_a", haz_a, 0);
            chk("rst_fwd_a", fwd_a, 0);
            chk("rst_stall_a", stall_a, 0);
            chk("rst_stall_c", stall_c, 0);
            chk("rst_haz_b", haz_b, 0);
            chk("rst_stall_b", stall_b, 0);
        end else begin
            any = 1'b0; ef = 0;
            for (int i = 0; i < 2; i++) begin
                s = src[i*4 +: 4];
                c = cnt_of(last_a[s], 3, cyc);
                if (used[i]) begin
                    any |= conflict_of(fe, c, ld_a[s], 3);
                    if (c == 3) ef |= 1 << (2*i);
                    else if (c == 2) ef |= 2 << (2*i);
                end
            end
            eh = valid && !flush && any;
            if (!fe || eh) ef = 0;
            chk("haz_a", haz_a, eh);
            chk("fwd_a", fwd_a, ef);
            chk("stall_a", stall_a, stalls_a);
            chk("haz_c", haz_c, eh);
            chk("fwd_c", fwd_c, ef);
            chk("stall_c", stall_c, (stalls_a > 3) ? 3 : stalls_a);
            if (eh) stalls_a++;
            if (valid && !flush && !eh && wb) begin
                last_a[dest] = cyc;
                ld_a[dest]   = mr;
            end

            any = 1'b0; ef = 0;
            for (int i = 0; i < 3; i++) begin
                s = src_b[i*4 +: 4];
                c = cnt_of(last_b[s], 5, cyc);
                if (used_b[i]) begin
                    any |= conflict_of(fe_b, c, ld_b[s], 5);
                    if (c == 5) ef |= 1 << (2*i);
                    else if (c == 4) ef |= 2 << (2*i);
                end
            end
            eh = valid_b && !flush_b && any;
            if (!fe_b || eh) ef = 0;
            chk("haz_b", haz_b, eh);
            chk("fwd_b", fwd_b, ef);
            chk("stall_b", stall_b, stalls_b);
            if (eh) stalls_b++;
            if (valid_b && !flush_b && !eh && wb_b) begin
                last_b[dest_b] = cyc;
                ld_b[dest_b]   = mr_b;
            end
        end
    end

    task automatic set_a(input bit v, input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] u,
                         input bit [3:0] d, input bit w, input bit m, input bit fl);
        valid = v; src = {s1, s0}; used = u; dest = d; wb = w; mr = m; flush = fl;
    endtask

    // Holds an instruction in ID until it issues; reports stall cycles and fwd_sel at issue.
    task automatic send_a(input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] u,
                          input bit [3:0] d, input bit w, input bit m,
                          output int stalls, output int fsel);
        bit done = 1'b0;
        set_a(1'b1, s0, s1, u, d, w, m, 1'b0);
        stalls = 0;
        fsel = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!haz_a) begin
                done = 1'b1;
                fsel = fwd_a;
                break;
            end
            stalls++;
        end
        if (!done) chk("timeout_a", 1, 0);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic send_b(input bit [3:0] s0, input bit [3:0] s1, input bit [3:0] s2,
                          input bit [2:0] u, input bit [3:0] d, input bit w, input bit m,
                          output int stalls, output int fsel);
        bit done = 1'b0;
        valid_b = 1'b1; src_b = {s2, s1, s0}; used_b = u; dest_b = d; wb_b = w; mr_b = m;
        flush_b = 1'b0;
        stalls = 0;
        fsel = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!haz_b) begin
                done = 1'b1;
                fsel = fwd_b;
                break;
            end
            stalls++;
        end
        if (!done) chk("timeout_b", 1, 0);
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st, fs;
        rst_n = 1'b0;
        fe = 1'b0;
        set_a(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        fe_b = 1'b0; valid_b = 1'b0; flush_b = 1'b0; wb_b = 1'b0; mr_b = 1'b0;
        src_b = '0; used_b = '0; dest_b = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_haz", haz_a, 0);
        chk("reset_stall", stall_a, 0);
        @(posedge clk); #1;

        // Stall-only: consumer of r1 right behind its producer waits two cycles
        fe = 1'b0;
        send_a(4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0, st, fs);
        send_a(4'd1, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("nofwd_stalls", st, 2);
        chk("nofwd_stall_count", stall_a, 2);
        idle(4);

        // Forwarding: EXE, then MEM, then register file
        fe = 1'b1;
        send_a(4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0, st, fs);
        send_a(4'd1, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("fwd_exe_stalls", st, 0);
        chk("fwd_exe_sel", fs, 1);
        send_a(4'd1, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("fwd_mem_sel", fs, 2);
        send_a(4'd1, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("fwd_rf_sel", fs, 0);
        idle(4);

        // Load-use on source 1: one bubble, then MEM forward
        send_a(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1, st, fs);
        send_a(4'd0, 4'd2, 2'b10, 4'd5, 1'b0, 1'b0, st, fs);
        chk("load_use_stalls", st, 1);
        chk("load_use_sel", fs, 8);
        chk("load_use_stall_count", stall_a, 3);
        idle(4);

        // WAW: younger ALU writer of r3 replaces the older load
        send_a(4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b1, st, fs);
        send_a(4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0, st, fs);
        send_a(4'd3, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("waw_stalls", st, 0);
        chk("waw_sel", fs, 1);
        idle(4);

        // Unused source never conflicts; flushed instruction leaves no entry
        send_a(4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1, st, fs);
        send_a(4'd4, 4'd0, 2'b10, 4'd5, 1'b0, 1'b0, st, fs);
        chk("unused_src_stalls", st, 0);
        chk("unused_src_sel", fs, 0);
        idle(4);
        send_a(4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b1, st, fs);
        set_a(1'b1, 4'd8, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_haz", haz_a, 0);
        @(posedge clk); #1;
        fe = 1'b0;
        send_a(4'd6, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, st, fs);
        chk("flush_no_entry_stalls", st, 0);
        idle(4);

        // Saturation of the CW=2 twin, then reset in the middle of a stall
        send_a(4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b0, st, fs);
        set_a(1'b1, 4'd7, 4'd0, 2'b01, 4'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("midstall_haz", haz_a, 1);
        @(negedge clk);
        chk("midstall_haz2", haz_a, 1);
        chk("midstall_count_a", stall_a, 4);
        chk("saturated_count_c", stall_c, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_haz", haz_a, 0);
        chk("async_rst_stall", stall_a, 0);
        chk("async_rst_stall_c", stall_c, 0);
        idle(0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Deep pipe, three sources
        fe_b = 1'b1;
        send_b(4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1'b1, 1'b0, st, fs);
        send_b(4'd0, 4'd0, 4'd9, 3'b100, 4'd5, 1'b0, 1'b0, st, fs);
        chk("deep_exe_stalls", st, 0);
        chk("deep_exe_sel", fs, 16);
        send_b(4'd0, 4'd9, 4'd0, 3'b010, 4'd5, 1'b0, 1'b0, st, fs);
        chk("deep_mem_sel", fs, 8);
        send_b(4'd9, 4'd0, 4'd0, 3'b001, 4'd5, 1'b0, 1'b0, st, fs);
        chk("deep_bubble_stalls", st, 2);
        chk("deep_bubble_sel", fs, 0);
        chk("deep_stall_count", stall_b, 2);
        send_b(4'd0, 4'd0, 4'd0, 3'b000, 4'd10, 1'b1, 1'b1, st, fs);
        send_b(4'd10, 4'd0, 4'd0, 3'b001, 4'd5, 1'b0, 1'b0, st, fs);
        chk("deep_load_stalls", st, 1);
        chk("deep_load_sel", fs, 2);
        chk("deep_load_stall_count", stall_b, 3);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
